// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, default bit timing and frame shape.
// The receiver imports the same package so both ends agree on frame layout.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;

    // 27 MHz board clock divided down to 115200 baud
    localparam int DEFAULT_DELAY_FRAMES = 234;
    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and first-word-fall-through read data.
// Pushes while full and pops while empty are ignored, so callers may gate loosely.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     wrEn,
    input  logic                     rdEn,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (count == (PTR_W+1)'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = wrEn && !full;
    assign doPop  = rdEn && !empty;
    assign rdData = mem[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and leave LSB first at one bit
// per DELAY_FRAMES clocks, with queued frames sent back-to-back.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int              CNT_W    = $clog2(DELAY_FRAMES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_FRAMES - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    txState_t         state, stateNext;
    logic [CNT_W-1:0] bitCnt, cntNext;
    logic [2:0]       bitIdx, idxNext;
    logic [7:0]       shiftReg, shiftNext;
    logic             txReg, txNext;
    logic             bitDone;
    logic             pop;
    logic             push;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [7:0]       fifoData;

    assign in_ready = !rst && !fifoFull;
    assign push     = in_valid && in_ready;
    assign bitDone  = (bitCnt == CNT_LAST);
    assign uart_tx  = txReg;
    assign busy     = (state != IDLE) || (fifo_count != '0);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) txFifo (
        .clk    (clk),
        .rst    (rst),
        .wrData (in_data),
        .wrEn   (push),
        .rdEn   (pop),
        .rdData (fifoData),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (fifo_count)
    );

    always_comb begin
        stateNext = state;
        cntNext   = bitCnt;
        idxNext   = bitIdx;
        shiftNext = shiftReg;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    shiftNext = fifoData;
                    cntNext   = '0;
                    stateNext = START;
                end
            end
            START: begin
                if (bitDone) begin
                    cntNext   = '0;
                    idxNext   = '0;
                    stateNext = DATA;
                end else begin
                    cntNext = bitCnt + 1'b1;
                end
            end
            DATA: begin
                if (bitDone) begin
                    cntNext   = '0;
                    shiftNext = shiftReg >> 1;
                    if (bitIdx == LAST_BIT) stateNext = STOP;
                    else                    idxNext   = bitIdx + 1'b1;
                end else begin
                    cntNext = bitCnt + 1'b1;
                end
            end
            STOP: begin
                // Chaining straight into START keeps queued frames gap-free
                if (bitDone) begin
                    cntNext = '0;
                    if (!fifoEmpty) begin
                        pop       = 1'b1;
                        shiftNext = fifoData;
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    cntNext = bitCnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase

        // Line level is computed for the upcoming state so the output flop lines up with it
        case (stateNext)
            START:   txNext = 1'b0;
            DATA:    txNext = shiftNext[0];
            default: txNext = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bitCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            txReg    <= 1'b1;
        end else begin
            state    <= stateNext;
            bitCnt   <= cntNext;
            bitIdx   <= idxNext;
            shiftReg <= shiftNext;
            txReg    <= txNext;
        end
    end

endmodule
